// File: rtl/timer_pkg.sv
// Shared definitions for bus_timer: register word indices,
// CTRL bit positions and the CTRL register layout.
package timer_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // Packed so that enable lands on bit 0 of the bus word.
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/system_bus.sv
// System bus connection between one leader and one follower slot.
// Leader drives request fields; follower returns read data + valid.
interface system_bus;

  logic [31:0] addr;
  logic        read_req;
  logic        write_req;
  logic [3:0]  byte_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_data_valid;

  modport leader (
    output addr, read_req, write_req,
    output byte_enable, write_data,
    input  read_data, read_data_valid
  );

  modport follower (
    input  addr, read_req, write_req,
    input  byte_enable, write_data,
    output read_data, read_data_valid
  );

endinterface

// File: rtl/timer_prescaler.sv
// Divides the clock into a one-cycle tick every PrescaleDiv cycles.
// Ports: clk, reset (async, high), enable in; tick out.
module timer_prescaler #(
  parameter int PrescaleDiv = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(PrescaleDiv) + 1;
  localparam logic [W-1:0] LAST = W'(PrescaleDiv - 1);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = enable && w_last;

  // Dropping enable restarts the division from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!enable || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer follower: CTRL, COUNT, COMPARE, STATUS.
// Ports: clk, reset (async, high), bus (follower), irq (level).
module bus_timer
  import timer_pkg::*;
#(
  parameter int          PrescaleDiv  = 1,
  parameter logic [31:0] ResetCompare = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       reset,
  system_bus.follower bus,
  output logic       irq
);

  ctrl_t       r_ctrl;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic [1:0]  w_idx;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_stat;
  logic        w_clr;
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_count_nxt;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
    end
    return m;
  endfunction

  // Slot selection is done by the bus; only the word index matters.
  assign w_idx    = bus.addr[3:2];
  assign w_unused = ^{bus.addr[31:4], bus.addr[1:0]};

  assign w_wr_ctrl  = bus.write_req && (w_idx == REG_CTRL);
  assign w_wr_count = bus.write_req && (w_idx == REG_COUNT);
  assign w_wr_cmp   = bus.write_req && (w_idx == REG_COMPARE);
  assign w_wr_stat  = bus.write_req && (w_idx == REG_STATUS);
  assign w_clr      = w_wr_stat && bus.byte_enable[0]
                      && bus.write_data[0];

  timer_prescaler #(
    .PrescaleDiv(PrescaleDiv)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .enable(r_ctrl.enable),
    .tick  (w_tick)
  );

  assign w_hit = w_tick && (r_count == r_compare);

  assign w_count_nxt = (w_hit && r_ctrl.auto_reload)
                       ? 32'd0 : r_count + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl && bus.byte_enable[0]) begin
      r_ctrl.enable      <= bus.write_data[CTRL_EN];
      r_ctrl.auto_reload <= bus.write_data[CTRL_AR];
      r_ctrl.irq_en      <= bus.write_data[CTRL_IE];
    end
  end

  // Bus write beats the tick update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= f_merge(r_count, bus.write_data,
                         bus.byte_enable);
    end else if (w_tick) begin
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_compare <= ResetCompare;
    end else if (w_wr_cmp) begin
      r_compare <= f_merge(r_compare, bus.write_data,
                           bus.byte_enable);
    end
  end

  // A new match outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match <= 1'b0;
    end else if (w_hit) begin
      r_match <= 1'b1;
    end else if (w_clr) begin
      r_match <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_idx)
      REG_CTRL:    w_rdata = {29'd0, r_ctrl};
      REG_COUNT:   w_rdata = r_count;
      REG_COMPARE: w_rdata = r_compare;
      REG_STATUS:  w_rdata = {31'd0, r_match};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= bus.read_req;
      if (bus.read_req) r_rdata <= w_rdata;
    end
  end

  assign bus.read_data       = r_rdata;
  assign bus.read_data_valid = r_rvalid;
  assign irq = r_match && r_ctrl.irq_en;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: two instances
// (PrescaleDiv 1 and 4), read scoreboard plus direct checks.
module tb_bus_timer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  system_bus b1 ();
  system_bus b4 ();
  logic irq1, irq4;

  bus_timer #(.PrescaleDiv(1)) d1 (
    .clk(clk), .reset(reset), .bus(b1), .irq(irq1)
  );
  bus_timer #(.PrescaleDiv(4)) d4 (
    .clk(clk), .reset(reset), .bus(b4), .irq(irq4)
  );

  logic [31:0] t_addr, t_wd;
  logic [3:0]  t_be;
  logic        t_rd, t_wr;
  int          sel;

  assign b1.addr        = t_addr;
  assign b1.write_data  = t_wd;
  assign b1.byte_enable = t_be;
  assign b1.read_req    = t_rd && (sel == 0);
  assign b1.write_req   = t_wr && (sel == 0);
  assign b4.addr        = t_addr;
  assign b4.write_data  = t_wd;
  assign b4.byte_enable = t_be;
  assign b4.read_req    = t_rd && (sel == 1);
  assign b4.write_req   = t_wr && (sel == 1);

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          dut;
    logic [31:0] exp;
    int          due;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input int d, input logic [31:0] act);
    sb_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL rd_extra dut%0d: got %h want none", d, act);
    end else begin
      e = sbq.pop_front();
      if (e.dut != d || e.exp !== act || e.due != cyc) begin
        n_err++;
        $display("FAIL rd dut%0d cyc%0d: got %h want %h dut%0d cyc%0d",
                 d, cyc, act, e.exp, e.dut, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (b1.read_data_valid) chk_rd(0, b1.read_data);
    if (b4.read_data_valid) chk_rd(1, b4.read_data);
  end

  task automatic op(input logic rd, input logic wr,
                    input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] wd, input logic [31:0] exp);
    t_rd = rd; t_wr = wr; t_addr = a; t_be = be; t_wd = wd;
    if (rd) sbq.push_back('{sel, exp, cyc + 1});
    @(posedge clk); #1;
    t_rd = 1'b0; t_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp);
    op(1'b1, 1'b0, a, 4'h0, 32'h0, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    op(1'b0, 1'b1, a, 4'hF, wd, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 4'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h04, 4'h0, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0C, 4'h0, 32'h0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h08, 4'h5, 32'hAABB_CCDD, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 32'hFFBB_FFDD};
    tbl[7]  = '{1'b0, 1'b1, 32'h08, 4'h0, 32'h0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 32'hFFBB_FFDD};
    tbl[9]  = '{1'b0, 1'b1, 32'h18, 4'hF, 32'h5, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h08, 4'h0, 32'h0, 32'h5};

    t_rd = 0; t_wr = 0; t_addr = 0; t_be = 0; t_wd = 0;
    sel = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_irq1", irq1, 1'b0);
    chk("rst_irq4", irq4, 1'b0);
    chk("rst_valid", b1.read_data_valid, 1'b0);
    chk("rst_rdata", b1.read_data, 32'h0);

    // Reset values, aliasing, byte enables.
    for (int i = 0; i < 11; i++) begin
      op(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be,
         tbl[i].wd, tbl[i].exp);
    end
    idle(2);
    chk("hold_valid", b1.read_data_valid, 1'b0);
    chk("hold_rdata", b1.read_data, 32'h5);
    chk("pre_irq1", irq1, 1'b0);

    // Auto-reload at COMPARE=5, back-to-back reads.
    wr(32'h0, 32'h7);
    for (int k = 0; k < 7; k++) begin
      rd(32'h4, (k < 6) ? 32'(k) : 32'h0);
    end
    chk("irq_set", irq1, 1'b1);
    wr(32'hC, 32'h1);
    chk("irq_w1c", irq1, 1'b0);
    idle(3);
    // Clear lands on the next match tick: match must win.
    wr(32'hC, 32'h1);
    chk("irq_w1c_race", irq1, 1'b1);
    rd(32'hC, 32'h1);

    // Bus write beats tick; read+write returns old value.
    wr(32'h4, 32'd100);
    rd(32'h4, 32'd100);
    op(1'b1, 1'b1, 32'h4, 4'hF, 32'd7, 32'd101);
    rd(32'h4, 32'd7);

    // Wrap without flag, then match at COMPARE=0.
    wr(32'h0, 32'h0);
    wr(32'h4, 32'hFFFF_FFFE);
    wr(32'h8, 32'h0);
    wr(32'hC, 32'h1);
    wr(32'h0, 32'h1);
    rd(32'h4, 32'hFFFF_FFFE);
    rd(32'h4, 32'hFFFF_FFFF);
    rd(32'hC, 32'h0);
    rd(32'h4, 32'h1);
    rd(32'hC, 32'h1);
    chk("irq_masked", irq1, 1'b0);

    // Prescaler of 4.
    sel = 1;
    wr(32'h0, 32'h1);
    idle(9);
    wr(32'h0, 32'h0);
    idle(5);
    rd(32'h4, 32'h2);
    wr(32'h0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      rd(32'h4, (k < 4) ? 32'h2 : 32'h3);
    end
    chk("irq4_idle", irq4, 1'b0);

    // Reset during a pending read response.
    sel = 0;
    wr(32'h0, 32'h5);
    chk("irq_en_on", irq1, 1'b1);
    t_rd = 1'b1; t_addr = 32'h8;
    @(posedge clk); #1;
    t_rd = 1'b0;
    chk("pend_valid", b1.read_data_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_drop_valid", b1.read_data_valid, 1'b0);
    chk("rst_drop_rdata", b1.read_data, 32'h0);
    chk("rst_irq", irq1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(32'h0, 32'h0);
    rd(32'h4, 32'h0);
    rd(32'h8, 32'hFFFF_FFFF);
    rd(32'hC, 32'h0);
    idle(3);

    while (sbq.size() != 0) begin
      sb_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL rd_missing dut%0d: got none want %h",
               e.dut, e.exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
